// File: rtl/mem_access.sv
// CPU-to-memory load/store unit: aligns store data and byte enables, extracts and extends load data.
// Misaligned or illegal requests and ack timeouts produce an error response.
module mem_access #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_en,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        we_q;
  logic [2:0]  type_q;
  logic [1:0]  off_q;

  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        bad_c;
  logic [31:0] lane;
  logic [31:0] load_c;

  // Request decode: lane mask, replicated store data, misalignment/illegal type
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = req_wdata;
    bad_c   = 1'b0;
    case (req_type)
      3'd0: begin
        be_c  = 4'b1111;
        bad_c = (req_addr[1:0] != 2'b00);
      end
      3'd1, 3'd2: begin
        be_c    = 4'(4'b0011 << req_addr[1:0]);
        wdata_c = {2{req_wdata[15:0]}};
        bad_c   = req_addr[0];
      end
      3'd3, 3'd4: begin
        be_c    = 4'(4'b0001 << req_addr[1:0]);
        wdata_c = {4{req_wdata[7:0]}};
      end
      default: bad_c = 1'b1;
    endcase
  end

  // Load extraction: shift the addressed lane down, then extend per type
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (type_q)
      3'd1:    load_c = {16'h0000, lane[15:0]};
      3'd2:    load_c = {{16{lane[15]}}, lane[15:0]};
      3'd3:    load_c = {24'h000000, lane[7:0]};
      3'd4:    load_c = {{24{lane[7]}}, lane[7:0]};
      default: load_c = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      we_q      <= 1'b0;
      type_q    <= 3'd0;
      off_q     <= 2'd0;
      req_ready <= 1'b1;
      mem_en    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            type_q    <= req_type;
            off_q     <= req_addr[1:0];
            req_ready <= 1'b0;
            if (bad_c) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 2'b01;
              rsp_rdata <= 32'h0;
            end else begin
              state     <= ACCESS;
              cnt       <= 8'd0;
              mem_en    <= 1'b1;
              mem_be    <= be_c;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= wdata_c;
            end
          end
        end
        ACCESS: begin
          // Ack wins over a timeout landing in the same cycle
          if (mem_ack) begin
            state     <= RESP;
            mem_en    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b00;
            rsp_rdata <= we_q ? 32'h0 : load_c;
          end else if (8'(cnt + 8'd1) == TIMEOUT) begin
            state     <= RESP;
            mem_en    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b10;
            rsp_rdata <= 32'h0;
          end else begin
            cnt <= 8'(cnt + 8'd1);
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, error paths, timeout and reset abort.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        mem_en;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  int checks = 0;
  int errors = 0;

  // Observations returned by the driver
  logic        en_seen;
  logic [3:0]  be;
  logic [31:0] ma;
  logic [31:0] mw;
  logic [31:0] rr;
  logic [1:0]  er;
  int          lat;
  logic        st;
  logic        rdy;

  mem_access #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Issues one request from IDLE; latency counts the accept cycle as 1. ack_after < 0 never acks.
  task automatic drive(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int ack_after);
    int en_cyc;
    en_seen = 1'b0; be = 4'h0; ma = 32'h0; mw = 32'h0; rr = 32'h0; er = 2'b00;
    lat = -1; st = 1'b1; rdy = 1'b0; en_cyc = 0;
    req_valid = 1'b1; req_we = we; req_type = typ; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_type = 3'd7; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    for (int cyc = 2; cyc < 300; cyc++) begin
      if (rsp_valid) begin
        lat = cyc; rr = rsp_rdata; er = rsp_err;
        break;
      end
      if (mem_en) begin
        if (!en_seen) begin be = mem_be; ma = mem_addr; mw = mem_wdata; end
        else if (mem_be !== be || mem_addr !== ma || mem_wdata !== mw) st = 1'b0;
        en_seen = 1'b1;
        en_cyc++;
        mem_rdata = rdata;
        mem_ack = (ack_after >= 0) && (en_cyc == ack_after + 1);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    end
    @(posedge clk); #1;
    rdy = req_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; req_valid = 1'b0; mem_ack = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
    checks++; if ({mem_en, mem_be} !== 5'b0) begin errors++; $display("FAIL rst_mem_en_be got %b%b want 00000", mem_en, mem_be); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL rst_mem_addr_wdata got %h %h want 0 0", mem_addr, mem_wdata); end
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== 35'h0) begin errors++; $display("FAIL rst_rsp got v=%b e=%b d=%h want 0 00 0", rsp_valid, rsp_err, rsp_rdata); end
  endtask

  task automatic test_signed_byte();
    drive(1'b0, 3'd4, 32'h0000_0013, 32'h0, 32'hFA12_BC34, 0);
    checks++; if (ma !== 32'h0000_0010) begin errors++; $display("FAIL sb_addr got %h want 00000010", ma); end
    checks++; if (be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b want 1000", be); end
    checks++; if (rr !== 32'hFFFF_FFFA) begin errors++; $display("FAIL sb_rdata got %h want fffffffa", rr); end
    checks++; if (er !== 2'b00) begin errors++; $display("FAIL sb_err got %b want 00", er); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency got %0d want 3", lat); end
    checks++; if (rdy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL sb_after got ready=%b valid=%b want 1 0", rdy, rsp_valid); end
    checks++; if (rsp_rdata !== 32'hFFFF_FFFA) begin errors++; $display("FAIL sb_hold got %h want fffffffa", rsp_rdata); end
  endtask

  task automatic test_loads();
    drive(1'b0, 3'd1, 32'h0000_0002, 32'h0, 32'hFABC_1234, 0);
    checks++; if (rr !== 32'h0000_FABC || be !== 4'b1100) begin errors++; $display("FAIL hu_load got %h be=%b want 0000fabc 1100", rr, be); end
    drive(1'b0, 3'd2, 32'h0000_0002, 32'h0, 32'hFABC_1234, 0);
    checks++; if (rr !== 32'hFFFF_FABC) begin errors++; $display("FAIL hs_load got %h want fffffabc", rr); end
    drive(1'b0, 3'd2, 32'h0000_0000, 32'h0, 32'hFABC_1234, 0);
    checks++; if (rr !== 32'h0000_1234) begin errors++; $display("FAIL hs_pos_load got %h want 00001234", rr); end
    drive(1'b0, 3'd3, 32'h0000_0001, 32'h0, 32'hFA12_BC34, 0);
    checks++; if (rr !== 32'h0000_00BC || be !== 4'b0010) begin errors++; $display("FAIL bu_load got %h be=%b want 000000bc 0010", rr, be); end
    drive(1'b0, 3'd0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 2);
    checks++; if (rr !== 32'hCAFE_F00D || er !== 2'b00) begin errors++; $display("FAIL word_load got %h e=%b want cafef00d 00", rr, er); end
    checks++; if (lat !== 5 || st !== 1'b1) begin errors++; $display("FAIL word_wait got lat=%0d stable=%b want 5 1", lat, st); end
  endtask

  task automatic test_stores();
    drive(1'b1, 3'd3, 32'h0000_0005, 32'h0000_00BC, 32'hFFFF_FFFF, 0);
    checks++; if (be !== 4'b0010 || mw !== 32'hBCBC_BCBC) begin errors++; $display("FAIL bstore_lane got be=%b d=%h want 0010 bcbcbcbc", be, mw); end
    checks++; if (ma !== 32'h0000_0004 || rr !== 32'h0 || er !== 2'b00) begin errors++; $display("FAIL bstore_rsp got a=%h d=%h e=%b want 00000004 0 00", ma, rr, er); end
    drive(1'b1, 3'd1, 32'h0000_0002, 32'hAAAA_5678, 32'hFFFF_FFFF, 1);
    checks++; if (be !== 4'b1100 || mw !== 32'h5678_5678 || st !== 1'b1) begin errors++; $display("FAIL hstore got be=%b d=%h st=%b want 1100 56785678 1", be, mw, st); end
    drive(1'b1, 3'd0, 32'h0000_0008, 32'h1357_9BDF, 32'hFFFF_FFFF, 0);
    checks++; if (be !== 4'b1111 || mw !== 32'h1357_9BDF || ma !== 32'h0000_0008) begin errors++; $display("FAIL wstore got be=%b d=%h a=%h want 1111 13579bdf 00000008", be, mw, ma); end
  endtask

  task automatic test_misaligned();
    drive(1'b0, 3'd0, 32'h0000_0006, 32'h0, 32'h0, 0);
    checks++; if (er !== 2'b01 || lat !== 2 || en_seen !== 1'b0) begin errors++; $display("FAIL mis_word got e=%b lat=%0d en=%b want 01 2 0", er, lat, en_seen); end
    drive(1'b1, 3'd2, 32'h0000_0003, 32'h0, 32'h0, 0);
    checks++; if (er !== 2'b01 || en_seen !== 1'b0) begin errors++; $display("FAIL mis_half got e=%b en=%b want 01 0", er, en_seen); end
    drive(1'b0, 3'd5, 32'h0000_0000, 32'h0, 32'h0, 0);
    checks++; if (er !== 2'b01 || en_seen !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL illegal_type got e=%b en=%b rdy=%b want 01 0 1", er, en_seen, rdy); end
  endtask

  task automatic test_timeout();
    drive(1'b0, 3'd0, 32'h0000_0040, 32'h0, 32'h1111_1111, -1);
    checks++; if (er !== 2'b10 || rr !== 32'h0 || lat < 0) begin errors++; $display("FAIL timeout got e=%b d=%h lat=%0d want 10 0 >0", er, rr, lat); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL timeout_ready got %b want 1", rdy); end
    drive(1'b0, 3'd0, 32'h0000_0044, 32'h0, 32'h2222_3333, 3);
    checks++; if (er !== 2'b00 || rr !== 32'h2222_3333) begin errors++; $display("FAIL late_ack got e=%b d=%h want 00 22223333", er, rr); end
  endtask

  task automatic test_reset_abort();
    logic seen;
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'd0; req_addr = 32'h80; mem_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL abort_in_access got mem_en=%b want 1", mem_en); end
    reset = 1'b1; mem_ack = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_ack = 1'b0; req_valid = 1'b0;
    checks++; if (mem_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL abort_state got en=%b v=%b rdy=%b want 0 0 1", mem_en, rsp_valid, req_ready); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1 || mem_en === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_quiet got activity=%b want 0", seen); end
    drive(1'b0, 3'd0, 32'h0000_0100, 32'h0, 32'h1234_5678, 0);
    checks++; if (rr !== 32'h1234_5678 || er !== 2'b00 || lat !== 3) begin errors++; $display("FAIL post_abort_load got d=%h e=%b lat=%0d want 12345678 00 3", rr, er, lat); end
  endtask

  initial begin
    test_reset();
    test_signed_byte();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
